exec_alu_unit: RTL and testbench

Execute-stage consumer of the registered one-hot function enables and `dec_funct_vld` strobe produced by the function decoder. It covers all integer ALU instructions: OP, OP_IMM, LUI, AUIPC and NOP. It selects operands, computes the result and returns a registered writeback packet with a valid pulse. Non-shift ops finish in one cycle; shifts use an optional serial shifter, so the block has a busy/ready handshake back to decode.

---
 rtl/rv32_exec_pkg.sv | 47 ++++
 rtl/exec_serial_shifter.sv | 59 +++++
 rtl/exec_alu_unit.sv | 163 ++++++++++++++++
 tb/tb_exec_alu_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rv32_exec_pkg.sv
// Shared constants for the RV32I integer execute stage: op-enable bit indices,
// operand-select masks and the execute FSM state type.
package rv32_exec_pkg;

    localparam int XLEN     = 32;
    localparam int ALU_OP_W = 24;

    localparam int OP_ADD   = 0;
    localparam int OP_SUB   = 1;
    localparam int OP_SLT   = 2;
    localparam int OP_SLTU  = 3;
    localparam int OP_AND   = 4;
    localparam int OP_OR    = 5;
    localparam int OP_XOR   = 6;
    localparam int OP_SLL   = 7;
    localparam int OP_SRL   = 8;
    localparam int OP_SRA   = 9;
    localparam int OP_ADDI  = 10;
    localparam int OP_SLTI  = 11;
    localparam int OP_SLTIU = 12;
    localparam int OP_ANDI  = 13;
    localparam int OP_ORI   = 14;
    localparam int OP_XORI  = 15;
    localparam int OP_SLLI  = 16;
    localparam int OP_SRLI  = 17;
    localparam int OP_SRAI  = 18;
    localparam int OP_LUI   = 19;
    localparam int OP_AUIPC = 20;
    localparam int OP_NOP   = 21;

    // Enables whose second operand comes from the immediate.
    localparam logic [ALU_OP_W-1:0] I_TYPE_MASK =
        (ALU_OP_W'(1) << OP_ADDI)  | (ALU_OP_W'(1) << OP_SLTI) |
        (ALU_OP_W'(1) << OP_SLTIU) | (ALU_OP_W'(1) << OP_ANDI) |
        (ALU_OP_W'(1) << OP_ORI)   | (ALU_OP_W'(1) << OP_XORI) |
        (ALU_OP_W'(1) << OP_SLLI)  | (ALU_OP_W'(1) << OP_SRLI) |
        (ALU_OP_W'(1) << OP_SRAI);

    // Enables that write a destination register (everything except nop and spares).
    localparam logic [ALU_OP_W-1:0] WB_MASK = (ALU_OP_W'(1) << (OP_AUIPC + 1)) - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } exec_state_t;

endpackage

// File: rtl/exec_serial_shifter.sv
// One-bit-per-cycle shifter; done is asserted in the last shifting cycle with
// result carrying the final shifted value, so the caller can register it directly.
module exec_serial_shifter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dir,
    input  logic         arith,
    input  logic [W-1:0] operand,
    input  logic [4:0]   shamt,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    logic [W-1:0] acc_reg;
    logic [W-1:0] acc_next;
    logic [4:0]   cnt_reg;
    logic         dir_reg;
    logic         arith_reg;
    logic         busy_reg;

    // dir: 0 = left, 1 = right; arith replicates the sign bit on right shifts.
    assign acc_next = dir_reg ? {arith_reg & acc_reg[W-1], acc_reg[W-1:1]}
                              : {acc_reg[W-2:0], 1'b0};

    assign busy   = busy_reg;
    assign done   = busy_reg && (cnt_reg == 5'd1);
    assign result = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            cnt_reg   <= '0;
            dir_reg   <= 1'b0;
            arith_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else if (flush) begin
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (load && !busy_reg && (shamt != 5'd0)) begin
            acc_reg   <= operand;
            cnt_reg   <= shamt;
            dir_reg   <= dir;
            arith_reg <= arith;
            busy_reg  <= 1'b1;
        end else if (busy_reg) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg - 5'd1;
            if (cnt_reg == 5'd1) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_alu_unit.sv
// RV32I integer execute unit: operand select, ALU, optional serial shifter and a
// registered writeback packet with a one-cycle valid pulse.
module exec_alu_unit #(
    parameter int XLEN       = 32,
    parameter int FAST_SHIFT = 0
) (
    input  logic                               CLK,
    input  logic                               RSTN,
    input  logic                               dec_funct_vld,
    input  logic [rv32_exec_pkg::ALU_OP_W-1:0] alu_op_oh,
    input  logic [XLEN-1:0]                    rs1_data,
    input  logic [XLEN-1:0]                    rs2_data,
    input  logic [XLEN-1:0]                    imm,
    input  logic [XLEN-1:0]                    pc,
    input  logic [4:0]                         rd_addr,
    input  logic                               ex_flush,
    output logic                               ex_rdy,
    output logic                               ex_vld,
    output logic                               ex_rd_we,
    output logic [4:0]                         ex_rd_addr,
    output logic [XLEN-1:0]                    ex_rd_data,
    output logic                               ex_illegal
);
    import rv32_exec_pkg::*;

    exec_state_t     state;
    logic [4:0]      pend_addr_reg;
    logic            pend_we_reg;

    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] shift_res;
    logic [4:0]      shamt;
    logic            legal;
    logic            writes;
    logic            is_sll;
    logic            is_srl;
    logic            is_sra;
    logic            is_shift;
    logic            lt_s;
    logic            lt_u;
    logic            accept;
    logic            serial_start;
    logic            sh_busy;
    logic            sh_done;
    logic [XLEN-1:0] sh_result;

    assign ex_rdy = (state == IDLE);
    assign accept = dec_funct_vld && ex_rdy && !ex_flush;

    assign opb    = |(alu_op_oh & I_TYPE_MASK) ? imm : rs2_data;
    assign shamt  = opb[4:0];
    assign legal  = (alu_op_oh != '0) && ((alu_op_oh & (alu_op_oh - ALU_OP_W'(1))) == '0);
    assign writes = legal && |(alu_op_oh & WB_MASK);

    assign is_sll   = alu_op_oh[OP_SLL] | alu_op_oh[OP_SLLI];
    assign is_srl   = alu_op_oh[OP_SRL] | alu_op_oh[OP_SRLI];
    assign is_sra   = alu_op_oh[OP_SRA] | alu_op_oh[OP_SRAI];
    assign is_shift = is_sll | is_srl | is_sra;

    assign lt_s = $signed(rs1_data) < $signed(opb);
    assign lt_u = rs1_data < opb;

    assign serial_start = (FAST_SHIFT == 0) && legal && is_shift && (shamt != 5'd0);

    generate
        if (FAST_SHIFT != 0) begin : gen_fast
            always_comb begin
                shift_res = rs1_data;
                if (is_sll)      shift_res = rs1_data << shamt;
                else if (is_srl) shift_res = rs1_data >> shamt;
                else if (is_sra) shift_res = XLEN'($signed(rs1_data) >>> shamt);
            end
            assign sh_busy   = 1'b0;
            assign sh_done   = 1'b0;
            assign sh_result = '0;
        end else begin : gen_serial
            // Only zero-length shifts complete in one cycle; they pass rs1 through.
            assign shift_res = rs1_data;
            exec_serial_shifter #(.W(XLEN)) u_shifter (
                .clk     (CLK),
                .rst_n   (RSTN),
                .load    (accept && serial_start),
                .dir     (!is_sll),
                .arith   (is_sra),
                .operand (rs1_data),
                .shamt   (shamt),
                .flush   (ex_flush),
                .busy    (sh_busy),
                .done    (sh_done),
                .result  (sh_result)
            );
        end
    endgenerate

    always_comb begin
        alu_res = '0;
        if (alu_op_oh[OP_ADD] | alu_op_oh[OP_ADDI])        alu_res = rs1_data + opb;
        else if (alu_op_oh[OP_SUB])                        alu_res = rs1_data - opb;
        else if (alu_op_oh[OP_SLT] | alu_op_oh[OP_SLTI])   alu_res = {{(XLEN-1){1'b0}}, lt_s};
        else if (alu_op_oh[OP_SLTU] | alu_op_oh[OP_SLTIU]) alu_res = {{(XLEN-1){1'b0}}, lt_u};
        else if (alu_op_oh[OP_AND] | alu_op_oh[OP_ANDI])   alu_res = rs1_data & opb;
        else if (alu_op_oh[OP_OR] | alu_op_oh[OP_ORI])     alu_res = rs1_data | opb;
        else if (alu_op_oh[OP_XOR] | alu_op_oh[OP_XORI])   alu_res = rs1_data ^ opb;
        else if (is_shift)                                 alu_res = shift_res;
        else if (alu_op_oh[OP_LUI])                        alu_res = imm;
        else if (alu_op_oh[OP_AUIPC])                      alu_res = pc + imm;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state         <= IDLE;
            ex_vld        <= 1'b0;
            ex_rd_we      <= 1'b0;
            ex_illegal    <= 1'b0;
            ex_rd_addr    <= '0;
            ex_rd_data    <= '0;
            pend_addr_reg <= '0;
            pend_we_reg   <= 1'b0;
        end else begin
            ex_vld     <= 1'b0;
            ex_rd_we   <= 1'b0;
            ex_illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (serial_start) begin
                            state         <= SHIFT;
                            pend_addr_reg <= rd_addr;
                            pend_we_reg   <= (rd_addr != 5'd0);
                        end else begin
                            ex_vld     <= 1'b1;
                            ex_illegal <= !legal;
                            ex_rd_we   <= writes && (rd_addr != 5'd0);
                            ex_rd_addr <= rd_addr;
                            ex_rd_data <= writes ? alu_res : '0;
                        end
                    end
                end
                SHIFT: begin
                    if (ex_flush) begin
                        state <= IDLE;
                    end else if (sh_done) begin
                        state      <= IDLE;
                        ex_vld     <= 1'b1;
                        ex_rd_we   <= pend_we_reg;
                        ex_rd_addr <= pend_addr_reg;
                        ex_rd_data <= sh_result;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decode must not offer an op while a shift is in progress; it would be lost.
    a_no_drop: assert property (@(posedge CLK) disable iff (!RSTN)
        !(dec_funct_vld && !ex_rdy && !ex_flush));

    a_shift_tracks: assert property (@(posedge CLK) disable iff (!RSTN)
        (state == SHIFT) |-> sh_busy);

endmodule

// File: tb/tb_exec_alu_unit.sv
// Directed bench for exec_alu_unit: stimulus pushes expected writeback packets,
// a negedge monitor pops and compares them, including the expected arrival cycle.
module tb_exec_alu_unit;
    import rv32_exec_pkg::*;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        dec_funct_vld = 1'b0;
    logic [23:0] alu_op_oh = '0;
    logic [31:0] rs1_data = '0, rs2_data = '0, imm = '0, pc = '0;
    logic [4:0]  rd_addr = '0;
    logic        ex_flush = 1'b0;
    logic        ex_rdy, ex_vld, ex_rd_we, ex_illegal;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_rd_data;

    typedef struct {
        int          cyc;
        logic        we;
        logic        ill;
        logic [4:0]  addr;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    exec_alu_unit #(.XLEN(32), .FAST_SHIFT(0)) dut (
        .CLK(CLK), .RSTN(RSTN), .dec_funct_vld(dec_funct_vld), .alu_op_oh(alu_op_oh),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc), .rd_addr(rd_addr),
        .ex_flush(ex_flush), .ex_rdy(ex_rdy), .ex_vld(ex_vld), .ex_rd_we(ex_rd_we),
        .ex_rd_addr(ex_rd_addr), .ex_rd_data(ex_rd_data), .ex_illegal(ex_illegal)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [23:0] ob(input int i);
        return 24'(1) << i;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic send(input string nm, input logic [23:0] oh, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im, input logic [31:0] p,
                        input logic [4:0] rd, input logic fl, input bit push,
                        input logic we, input logic ill, input logic [31:0] d, input int extra);
        exp_t e;
        dec_funct_vld = 1'b1; alu_op_oh = oh; rs1_data = a; rs2_data = b;
        imm = im; pc = p; rd_addr = rd; ex_flush = fl;
        if (push) begin
            e.cyc = cyc + 1 + extra; e.we = we; e.ill = ill; e.addr = rd; e.data = d; e.name = nm;
            exp_q.push_back(e);
        end
        @(posedge CLK); #1;
        dec_funct_vld = 1'b0; ex_flush = 1'b0;
        $display("sent %s rs1=%h b=%h imm=%h rd=%0d at cycle %0d", nm, a, b, im, rd, cyc - 1);
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RSTN && ex_vld) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_vld: got data %0h at cycle %0d expected no result", ex_rd_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    $display("result %s data=%h we=%0b ill=%0b addr=%0d cycle %0d", e.name,
                             ex_rd_data, ex_rd_we, ex_illegal, ex_rd_addr, cyc);
                    chk({e.name, "_cycle"}, cyc, e.cyc);
                    chk({e.name, "_data"}, ex_rd_data, e.data);
                    chk({e.name, "_we"}, {31'b0, ex_rd_we}, {31'b0, e.we});
                    chk({e.name, "_ill"}, {31'b0, ex_illegal}, {31'b0, e.ill});
                    if (!e.ill) chk({e.name, "_addr"}, {27'b0, ex_rd_addr}, {27'b0, e.addr});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(3);
        RSTN = 1'b1;
        tick(1);
        chk("reset_rdy", {31'b0, ex_rdy}, 32'd1);
        chk("reset_vld", {31'b0, ex_vld}, 32'd0);
        chk("reset_data", ex_rd_data, 32'd0);
        chk("reset_addr", {27'b0, ex_rd_addr}, 32'd0);

        send("add", ob(OP_ADD), 5, 7, 0, 0, 3, 0, 1, 1, 0, 32'd12, 0);
        chk("add_rdy", {31'b0, ex_rdy}, 32'd1);
        send("slt", ob(OP_SLT), 32'hFFFF_FFFF, 1, 0, 0, 4, 0, 1, 1, 0, 32'd1, 0);
        send("sltu", ob(OP_SLTU), 32'hFFFF_FFFF, 1, 0, 0, 5, 0, 1, 1, 0, 32'd0, 0);
        send("auipc", ob(OP_AUIPC), 0, 0, 32'h1000, 32'h100, 6, 0, 1, 1, 0, 32'h1100, 0);
        send("sub", ob(OP_SUB), 5, 7, 0, 0, 7, 0, 1, 1, 0, 32'hFFFF_FFFE, 0);
        send("xori", ob(OP_XORI), 32'hF0F0_F0F0, 32'h1234, 32'hFFFF_FFFF, 0, 8, 0, 1, 1, 0, 32'h0F0F_0F0F, 0);
        send("lui", ob(OP_LUI), 32'h5, 32'h6, 32'h1234_5000, 0, 9, 0, 1, 1, 0, 32'h1234_5000, 0);
        send("and", ob(OP_AND), 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0, 16, 0, 1, 1, 0, 32'h0F00_0F00, 0);
        send("or", ob(OP_OR), 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0, 17, 0, 1, 1, 0, 32'hFFF0_FFF0, 0);
        send("slti", ob(OP_SLTI), 32'hFFFF_FFFB, 0, 32'hFFFF_FFFD, 0, 18, 0, 1, 1, 0, 32'd1, 0);
        send("sltiu", ob(OP_SLTIU), 5, 0, 32'hFFFF_FFFD, 0, 19, 0, 1, 1, 0, 32'd1, 0);
        tick(1);

        send("sra", ob(OP_SRA), 32'h8000_0000, 4, 0, 0, 10, 0, 1, 1, 0, 32'hF800_0000, 4);
        for (int i = 0; i < 4; i++) begin
            chk("sra_busy_rdy", {31'b0, ex_rdy}, 32'd0);
            tick(1);
        end
        chk("sra_done_rdy", {31'b0, ex_rdy}, 32'd1);

        send("sll31", ob(OP_SLL), 1, 31, 0, 0, 11, 0, 1, 1, 0, 32'h8000_0000, 31);
        tick(31);
        send("srl0", ob(OP_SRL), 32'h8000_0000, 32'h20, 0, 0, 12, 0, 1, 1, 0, 32'h8000_0000, 0);
        chk("srl0_rdy", {31'b0, ex_rdy}, 32'd1);

        send("srli_flushed", ob(OP_SRLI), 32'hFFFF_0000, 0, 8, 0, 20, 0, 0, 0, 0, 0, 0);
        tick(2);
        ex_flush = 1'b1;
        tick(1);
        ex_flush = 1'b0;
        chk("flush_rdy", {31'b0, ex_rdy}, 32'd1);
        send("add_after_flush", ob(OP_ADD), 1, 2, 0, 0, 13, 0, 1, 1, 0, 32'd3, 0);
        tick(10);

        send("add_idle_flush", ob(OP_ADD), 9, 9, 0, 0, 21, 1, 0, 0, 0, 0, 0);
        send("add_vld_flush", ob(OP_ADD), 32'h10, 32'h20, 0, 0, 22, 0, 1, 1, 0, 32'h30, 0);
        ex_flush = 1'b1;
        tick(1);
        ex_flush = 1'b0;

        send("illegal_multi", ob(OP_ADD) | ob(OP_OR), 5, 7, 0, 0, 14, 0, 1, 0, 1, 32'd0, 0);
        send("illegal_zero", 24'd0, 5, 7, 0, 0, 14, 0, 1, 0, 1, 32'd0, 0);
        send("addi_rd0", ob(OP_ADDI), 1, 32'h55, 2, 0, 0, 0, 1, 0, 0, 32'd3, 0);
        send("nop", ob(OP_NOP), 5, 7, 9, 0, 23, 0, 1, 0, 0, 32'd0, 0);
        send("lui_hold", ob(OP_LUI), 0, 0, 32'hABCD_E000, 0, 24, 0, 1, 1, 0, 32'hABCD_E000, 0);
        tick(2);

        send("sll_reset", ob(OP_SLL), 1, 10, 0, 0, 15, 0, 0, 0, 0, 0, 0);
        tick(3);
        RSTN = 1'b0;
        #1;
        chk("rst_mid_vld", {31'b0, ex_vld}, 32'd0);
        chk("rst_mid_we", {31'b0, ex_rd_we}, 32'd0);
        chk("rst_mid_ill", {31'b0, ex_illegal}, 32'd0);
        chk("rst_mid_data", ex_rd_data, 32'd0);
        chk("rst_mid_addr", {27'b0, ex_rd_addr}, 32'd0);
        tick(2);
        RSTN = 1'b1;
        tick(1);
        chk("rst_rel_rdy", {31'b0, ex_rdy}, 32'd1);
        send("add_after_reset", ob(OP_ADD), 100, 23, 0, 0, 25, 0, 1, 1, 0, 32'd123, 0);
        tick(15);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
